log_multiplier_pipe: RTL and testbench
======================================

LOG_MULTIPLIER_PIPE -- requirements
Module: log_multiplier_pipe

Interface
- REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits, legal range 4..32.
- REQ-002 SHALL have parameter EW = $clog2(WIDTH), derived: width of the leading-one position.
- REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst, input, 1: asynchronous active-high reset.
- REQ-005 SHALL have port in_valid, input, 1: operand pair present.
- REQ-006 SHALL have port in_ready, output, 1: block accepts an operand pair this cycle.
- REQ-007 SHALL have port n1, input, WIDTH: unsigned operand A.
- REQ-008 SHALL have port n2, input, WIDTH: unsigned operand B.
- REQ-009 SHALL have port out_valid, output, 1: result present.
- REQ-010 SHALL have port out_ready, input, 1: downstream accepts the result.
- REQ-011 SHALL have port p0, output, 2*WIDTH: approximate product.
- REQ-012 SHALL have ports zero_flag1 and zero_flag2, output, 1 each, present only under LOGMUL_ZERO_FLAGS_EN: n1 and n2 respectively were zero.

Function
- REQ-013 SHALL compute the Mitchell product: k = leading-one index, f = x XOR 2^k, p0 = 2^(k1+k2) + (f1<<k2) + (f2<<k1).
- REQ-014 SHALL force p0 = 0 when n1 == 0 or n2 == 0.
- REQ-015 SHALL be a 3-stage pipeline. S1: leading-one detect, encode k, extract f, register zero detect. S2: k1+k2 to EW+1 bits, both shifts. S3: decode 2^(k1+k2) plus the final add into the output register.
- REQ-016 SHALL give a latency of exactly 3 cycles from the in_valid&&in_ready edge to out_valid when out_ready stays high.
- REQ-017 SHALL sustain a throughput of one result per cycle when out_ready stays high.
- REQ-018 SHALL compute the stall term adv = !out_valid || out_ready; all stages advance together only when adv is high, and in_ready = adv.
- REQ-019 SHALL hold p0 and out_valid stable while out_valid && !out_ready.
- REQ-020 SHALL propagate bubbles, i.e. per-stage valid bits clear, when in_valid is low while adv is high.
- REQ-021 SHALL size all intermediate sums so that no overflow is possible; the worst case of all-ones operands is below 2^(2*WIDTH).
- REQ-022 SHALL have the combinational in_ready depend only on out_valid and out_ready, never on in_valid.

Reset
- REQ-023 SHALL, while rst is high, asynchronously clear all stage valid bits, out_valid, p0 and the zero flags to 0.
- REQ-024 SHALL discard any operands in flight when rst is asserted mid-stream; no result from them SHALL appear after reset.
- REQ-025 SHALL drive in_ready = 1 in the first cycle after reset deassertion.

Configuration
- REQ-026 SHALL provide macro LOGMUL_ZERO_FLAGS_EN. When defined, zero_flag1 and zero_flag2 exist and are pipelined alongside p0 with the same latency and stall behaviour.
- REQ-027 SHALL, when LOGMUL_ZERO_FLAGS_EN is undefined, omit the flag ports and their registers; zero forcing of p0 (REQ-014) remains in both builds.

Structure
- REQ-028 SHALL take the default WIDTH constant and a clog2 helper function from shared package log_mul_pkg.
- REQ-029 SHALL place the leading-one detector and position encoder in sub-module log_mul_lod (parameter WIDTH; outputs the k index, the fraction f and a zero flag), instantiated twice in S1.

Verification (WIDTH=16, out_ready=1 unless stated)
- REQ-030 SHALL cover n1=3, n2=5: p0=14 three cycles after acceptance; n1=12, n2=12: p0=128.
- REQ-031 SHALL cover power-of-two operands n1=256, n2=64: p0=16384 (exact), and n1=1, n2=1: p0=1.
- REQ-032 SHALL cover n1=0, n2=500: p0=0 (plus zero_flag1=1, zero_flag2=0 with LOGMUL_ZERO_FLAGS_EN); n1=0xFFFF, n2=0xFFFF: p0=3221159936.
- REQ-033 SHALL cover a back-to-back stream of 10 pairs with out_ready low for 4 cycles mid-stream: in_ready low during the stall, p0 held, all 10 results delivered in order with no loss or duplication.
- REQ-034 SHALL cover rst asserted with 3 pairs in flight: out_valid=0 immediately; no stale result after release; in_ready=1 on the next cycle.

Source files
------------

// File: rtl/log_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module  : log_mul_pkg
// Purpose : Shared constants and helpers for the Mitchell log multiplier.
//           Provides the default operand width and a ceil(log2) function used
//           to size the leading-one index.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package log_mul_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/log_mul_lod.sv
`default_nettype none
// ============================================================================
// Module  : log_mul_lod
// Purpose : Leading-one detector and position encoder. For a nonzero operand x
//           it returns k = index of the most significant set bit and the
//           fraction f = x with that bit cleared. A zero operand gives k = 0,
//           f = 0 and zero_o = 1.
// Ports   : x_i    [WIDTH-1:0]  operand
//           k_o    [EW-1:0]     leading-one index
//           f_o    [WIDTH-1:0]  fraction bits below the leading one
//           zero_o              operand is zero
// Revision: 1.0 - initial release
// ============================================================================
module log_mul_lod
  import log_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int EW    = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [EW-1:0]    k_o,
  output logic [WIDTH-1:0] f_o,
  output logic             zero_o
);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    k_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (x_i[i]) begin
        k_o = EW'(i);
      end
    end
  end

  assign zero_o = (x_i == '0);
  assign f_o    = zero_o ? '0 : (x_i ^ (WIDTH'(1) << k_o));

endmodule
`default_nettype wire

// File: rtl/log_multiplier_pipe.sv
`default_nettype none
// ============================================================================
// Module  : log_multiplier_pipe
// Purpose : 3-stage pipelined Mitchell approximate multiplier with a
//           valid/ready handshake on both sides.
//             p0 = 2^(k1+k2) + (f1 << k2) + (f2 << k1), forced to 0 if either
//             operand is zero.
//           S1: leading-one detect / fraction extract / zero detect
//           S2: exponent sum and both fraction shifts
//           S3: power-of-two decode plus final add into the output register
//           All stages advance together when adv = !out_valid || out_ready.
// Config  : LOGMUL_ZERO_FLAGS_EN - adds zero_flag1/zero_flag2 outputs,
//           pipelined alongside p0.
// Ports   : clk, rst (async, active high)
//           in_valid / in_ready, n1, n2 [WIDTH-1:0]   operand side
//           out_valid / out_ready, p0 [2*WIDTH-1:0]   result side
//           zero_flag1, zero_flag2                    (LOGMUL_ZERO_FLAGS_EN)
// Revision: 1.0 - initial release
// ============================================================================
module log_multiplier_pipe
  import log_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int EW    = clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   n1,
  input  logic [WIDTH-1:0]   n2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p0
`ifdef LOGMUL_ZERO_FLAGS_EN
  ,
  output logic               zero_flag1,
  output logic               zero_flag2
`endif
);

  localparam int PW = 2 * WIDTH;

  logic adv;

  // Stage 1
  logic [EW-1:0]    k1_d, k2_d;
  logic [WIDTH-1:0] f1_d, f2_d;
  logic             z1_d, z2_d;
  logic             v1_q;
  logic [EW-1:0]    k1_q, k2_q;
  logic [WIDTH-1:0] f1_q, f2_q;
  logic             z1_q, z2_q;

  // Stage 2
  logic [EW:0]      ksum_d;
  logic [PW-1:0]    sh1_d, sh2_d;
  logic             v2_q;
  logic [EW:0]      ksum_q;
  logic [PW-1:0]    sh1_q, sh2_q;
  logic             z1_s2_q, z2_s2_q;

  // Stage 3
  logic [PW-1:0]    pow_d;
  logic [PW-1:0]    p0_d;
  logic             out_valid_q;
  logic [PW-1:0]    p0_q;

  // Stall only when a result is waiting and downstream refuses it.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  log_mul_lod #(.WIDTH(WIDTH), .EW(EW)) u_lod1 (
    .x_i    (n1),
    .k_o    (k1_d),
    .f_o    (f1_d),
    .zero_o (z1_d)
  );

  log_mul_lod #(.WIDTH(WIDTH), .EW(EW)) u_lod2 (
    .x_i    (n2),
    .k_o    (k2_d),
    .f_o    (f2_d),
    .zero_o (z2_d)
  );

  // f < 2^k, so each shifted fraction is below 2^(k1+k2) <= 2^(2*WIDTH-2);
  // the final sum stays below 3*2^(2*WIDTH-2) and fits in PW bits.
  assign ksum_d = {1'b0, k1_q} + {1'b0, k2_q};
  assign sh1_d  = {{WIDTH{1'b0}}, f1_q} << k2_q;
  assign sh2_d  = {{WIDTH{1'b0}}, f2_q} << k1_q;

  assign pow_d  = PW'(1) << ksum_q;
  assign p0_d   = (z1_s2_q || z2_s2_q) ? '0 : (pow_d + sh1_q + sh2_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      k1_q        <= '0;
      k2_q        <= '0;
      f1_q        <= '0;
      f2_q        <= '0;
      z1_q        <= 1'b0;
      z2_q        <= 1'b0;
      v2_q        <= 1'b0;
      ksum_q      <= '0;
      sh1_q       <= '0;
      sh2_q       <= '0;
      z1_s2_q     <= 1'b0;
      z2_s2_q     <= 1'b0;
      out_valid_q <= 1'b0;
      p0_q        <= '0;
    end else if (adv) begin
      v1_q        <= in_valid;
      k1_q        <= k1_d;
      k2_q        <= k2_d;
      f1_q        <= f1_d;
      f2_q        <= f2_d;
      z1_q        <= z1_d;
      z2_q        <= z2_d;
      v2_q        <= v1_q;
      ksum_q      <= ksum_d;
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
      z1_s2_q     <= z1_q;
      z2_s2_q     <= z2_q;
      out_valid_q <= v2_q;
      p0_q        <= p0_d;
    end
  end

  assign out_valid = out_valid_q;
  assign p0        = p0_q;

`ifdef LOGMUL_ZERO_FLAGS_EN
  logic zf1_q, zf2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zf1_q <= 1'b0;
      zf2_q <= 1'b0;
    end else if (adv) begin
      zf1_q <= z1_s2_q;
      zf2_q <= z2_s2_q;
    end
  end

  assign zero_flag1 = zf1_q;
  assign zero_flag2 = zf2_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_log_multiplier_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_log_multiplier_pipe
// Purpose : Self-checking bench for log_multiplier_pipe (WIDTH = 16) using a
//           table of hand-computed Mitchell products plus stream/stall and
//           mid-stream reset sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_log_multiplier_pipe;

  localparam int WIDTH = 16;
  localparam int NVEC  = 12;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   n1;
  logic [WIDTH-1:0]   n2;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p0;
`ifdef LOGMUL_ZERO_FLAGS_EN
  logic               zero_flag1;
  logic               zero_flag2;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] p;
    logic               z1;
    logic               z2;
  } vec_t;

  vec_t tab [NVEC];

  log_multiplier_pipe #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .n1         (n1),
    .n2         (n2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .p0         (p0)
`ifdef LOGMUL_ZERO_FLAGS_EN
    ,
    .zero_flag1 (zero_flag1),
    .zero_flag2 (zero_flag2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    @(negedge clk);
    in_valid = 1'b1;
    n1       = tab[i].a;
    n2       = tab[i].b;
    @(negedge clk);               // accepted on the edge just passed
    in_valid = 1'b0;
    chk($sformatf("lat1_v%0d", i), 64'(out_valid), 64'd0);
    @(negedge clk);
    chk($sformatf("lat2_v%0d", i), 64'(out_valid), 64'd0);
    @(negedge clk);
    chk($sformatf("valid_v%0d", i), 64'(out_valid), 64'd1);
    chk($sformatf("p0_v%0d", i), 64'(p0), 64'(tab[i].p));
`ifdef LOGMUL_ZERO_FLAGS_EN
    chk($sformatf("zf1_v%0d", i), 64'(zero_flag1), 64'(tab[i].z1));
    chk($sformatf("zf2_v%0d", i), 64'(zero_flag2), 64'(tab[i].z2));
`endif
  endtask

  initial begin
    int idx;
    int rx;
    int cyc;
    logic acc;
    logic hold_valid;
    logic [2*WIDTH-1:0] held;

    //            a        b        p             z1    z2
    tab[0]  = '{16'd3,    16'd5,    32'd14,         1'b0, 1'b0};
    tab[1]  = '{16'd12,   16'd12,   32'd128,        1'b0, 1'b0};
    tab[2]  = '{16'd256,  16'd64,   32'd16384,      1'b0, 1'b0};
    tab[3]  = '{16'd1,    16'd1,    32'd1,          1'b0, 1'b0};
    tab[4]  = '{16'd0,    16'd500,  32'd0,          1'b1, 1'b0};
    tab[5]  = '{16'hFFFF, 16'hFFFF, 32'd3221159936, 1'b0, 1'b0};
    tab[6]  = '{16'd7,    16'd9,    32'd60,         1'b0, 1'b0};
    tab[7]  = '{16'd100,  16'd3,    32'd264,        1'b0, 1'b0};
    tab[8]  = '{16'd2,    16'd2,    32'd4,          1'b0, 1'b0};
    tab[9]  = '{16'd1000, 16'd1,    32'd1000,       1'b0, 1'b0};
    tab[10] = '{16'd5,    16'd0,    32'd0,          1'b0, 1'b1};
    tab[11] = '{16'hFFFF, 16'd1,    32'd65535,      1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n1        = '0;
    n2        = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_p0", 64'(p0), 64'd0);
`ifdef LOGMUL_ZERO_FLAGS_EN
    chk("rst_zf1", 64'(zero_flag1), 64'd0);
    chk("rst_zf2", 64'(zero_flag2), 64'd0);
`endif
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors, one at a time
    for (int i = 0; i < NVEC; i++) begin
      run_vec(i);
    end

    // Back-to-back stream of 10 pairs with a 4-cycle downstream stall
    idx        = 0;
    rx         = 0;
    cyc        = 0;
    hold_valid = 1'b0;
    held       = '0;
    while (rx < 10 && cyc < 200) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc < 9);
      if (idx < 10) begin
        in_valid = 1'b1;
        n1       = tab[idx].a;
        n2       = tab[idx].b;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (hold_valid) begin
        chk("stall_hold_p0", 64'(p0), 64'(held));
        chk("stall_hold_valid", 64'(out_valid), 64'd1);
      end
      hold_valid = 1'b0;
      if (!out_ready) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        if (out_valid) begin
          held       = p0;
          hold_valid = 1'b1;
        end
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk($sformatf("stream_p0_%0d", rx), 64'(p0), 64'(tab[rx].p));
        rx++;
      end
      @(posedge clk);
      if (acc) idx++;
      cyc++;
    end
    chk("stream_count", 64'(rx), 64'd10);
    chk("stream_sent", 64'(idx), 64'd10);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("stream_no_extra", 64'(out_valid), 64'd0);
    end

    // Reset with three pairs in flight
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      in_valid = 1'b1;
      n1       = tab[j].a;
      n2       = tab[j].b;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_p0", 64'(p0), 64'(tab[0].p));
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_p0", 64'(p0), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("rst_no_stale", 64'(out_valid), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
